// File: rtl/rotator_pkg.sv
// Shared definitions for the serial rotator family.
//   state_t       : FSM encoding (IDLE=0, ROTATE=1, DONE=2; 3 is illegal)
//   DEFAULT_WIDTH : default data word width
//   ROT_MAX_W     : widest word the helper function handles
//   rotl1()       : rotate a w-bit value (held in the low bits) left by one
package rotator_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int ROT_MAX_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // The value sits zero-extended in the low w bits of v. The bit shifted
    // out at position w-1 wraps into bit 0, and the mask drops whatever was
    // shifted past bit w-1, so no bit is lost or zero-filled.
    function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                   input int unsigned        w);
        logic [ROT_MAX_W-1:0] mask;
        mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
        return ((v << 1) | ((v >> (w - 1)) & ROT_MAX_W'(1))) & mask;
    endfunction

endpackage

// File: rtl/rotl_step.sv
// Combinational one-bit left rotate of a WIDTH-bit word.
//   d : word to rotate
//   q : d rotated left by one position (MSB wraps to LSB)
module rotl_step
    import rotator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    assign q = WIDTH'(rotl1(ROT_MAX_W'(d), WIDTH));

endmodule

// File: rtl/left_rotator_serial.sv
// Sequential left rotator: accepts a word and a rotate count, rotates the
// word left one bit per clock, then holds the result until it is taken.
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous reset, active low
//   d_in       : word to rotate, sampled on accept
//   bit_amount : left rotate count 0..WIDTH-1, sampled on accept
//   in_valid   : d_in / bit_amount are valid
//   in_ready   : block can accept (IDLE only)
//   d_out      : rotated result, meaningful while out_valid=1
//   out_valid  : d_out holds a completed result (DONE)
//   out_ready  : consumer takes the result
//   busy       : high in ROTATE or DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its data stable while valid is high and ready
// is low; ready never depends combinationally on valid. in_ready and
// out_valid are decoded from the state register only.
//
// WIDTH must be a power of two and at least 2.
module left_rotator_serial
    import rotator_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic [AMT_W-1:0] bit_amount,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_rot;
    logic [AMT_W-1:0] count_q;

    // Single shared rotate step on the feedback path.
    rotl_step #(.WIDTH(WIDTH)) u_step (
        .d (data_q),
        .q (data_rot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= d_in;
                        count_q <= bit_amount;
                    end
                end
                ST_ROTATE: begin
                    // ROTATE is only entered with count_q >= 1, so this
                    // decrement never wraps.
                    data_q  <= data_rot;
                    count_q <= count_q - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = (bit_amount == '0) ? ST_DONE : ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                if (count_q == AMT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            // The unused encoding 2'd3 falls back to IDLE.
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ROTATE) || (state == ST_DONE);
    assign d_out     = data_q;

endmodule

// File: tb/tb_left_rotator_serial.sv
module tb_left_rotator_serial;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_in;
  logic [2:0] bit_amount;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_bad    = 0;
  int n_got    = 0;
  int n_sent   = 0;
  logic [7:0] exp_q[$];

  left_rotator_serial #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .bit_amount (bit_amount),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_out      (d_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // golden rotate-left: upper byte of the doubled word shifted left
  function automatic logic [7:0] rotl_ref(input logic [7:0] d, input logic [2:0] a);
    logic [15:0] t;
    t = {d, d} << a;
    return t[15:8];
  endfunction

  // scoreboard: a result is taken when out_valid and out_ready are both high
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(d_out), 32'hffff_ffff);
      end else begin
        chk("d_out", 32'(d_out), 32'(exp_q.pop_front()));
      end
      n_got++;
    end
  end

  // driver tasks
  task automatic drive_word(input logic [7:0] d, input logic [2:0] a);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
    d_in       = d;
    bit_amount = a;
    in_valid   = 1'b1;
    exp_q.push_back(rotl_ref(d, a));
    n_sent++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // counts negedges after the accept edge until out_valid; busy_all tracks busy
  task automatic wait_valid(output int cycles, output logic busy_all);
    cycles   = 0;
    busy_all = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
      busy_all = busy_all & busy;
    end while (!out_valid && cycles < 100);
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int   lat;
  logic ball;

  initial begin
    rst_n      = 1'b0;
    d_in       = '0;
    bit_amount = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 81 rotl 1 -> 03, valid 2 cycles after accept
    drive_word(8'h81, 3'd1);
    wait_valid(lat, ball);
    chk("lat_amt1", 32'(lat), 32'd2);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    consume();
    chk("idle_after_1", 32'(in_ready), 32'd1);
    chk("valid_drop_1", 32'(out_valid), 32'd0);

    // B4 rotl 3 -> A5, busy for the whole interval
    drive_word(8'hB4, 3'd3);
    wait_valid(lat, ball);
    chk("lat_amt3", 32'(lat), 32'd4);
    chk("busy_span3", 32'(ball), 32'd1);
    consume();

    // 5C rotl 0 -> 5C, valid in the cycle after accept
    drive_word(8'h5C, 3'd0);
    wait_valid(lat, ball);
    chk("lat_amt0", 32'(lat), 32'd1);
    consume();

    // 01 rotl 7 -> 80 held under backpressure
    drive_word(8'h01, 3'd7);
    wait_valid(lat, ball);
    chk("lat_amt7", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_d_out", 32'(d_out), 32'h80);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    consume();
    chk("idle_after_7", 32'(in_ready), 32'd1);

    // reset in the 3rd ROTATE cycle discards the word
    drive_word(8'hF0, 3'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_d_out", 32'(d_out), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    n_sent--;
    drive_word(8'h0F, 3'd4);
    wait_valid(lat, ball);
    chk("lat_after_rst", 32'(lat), 32'd5);
    consume();

    // sweep: every value x every amount, in_valid held high throughout,
    // random garbage on the inputs while busy, random out_ready gaps
    begin
      int k;
      int guard;
      k     = 0;
      guard = 0;
      @(posedge clk); #1;
      while (k < 2048 && guard < 80000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = 1'b1;
        if (in_ready) begin
          d_in       = 8'(k % 256);
          bit_amount = 3'(k / 256);
          exp_q.push_back(rotl_ref(8'(k % 256), 3'(k / 256)));
          n_sent++;
          k++;
        end else begin
          d_in       = 8'($urandom_range(0, 255));
          bit_amount = 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("sweep_sent", 32'(k), 32'd2048);
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      repeat (3) @(posedge clk);
      #1;
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    chk("result_count", 32'(n_got), 32'(n_sent));
    chk("final_idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
